// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter producing the index/enable pair for a 2-to-4 grant decoder.
// Owns rotation, grant hold, hold timeout and the mandatory idle gap between grants.
module rr_arb4 #(
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [1:0] gnt_idx,
   output logic       gnt_en,
   output logic       timeout,
   output logic       busy
);

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   last;
   logic [CNT_W-1:0]   hold_cnt;
   logic [IDX_W-1:0]   pick_c;
   logic               any_c;
   logic [IDX_W-1:0]   cand_c;

   // Rotating priority search last+1 .. last+4; iterating downwards lets the nearest hit win.
   always_comb begin
      pick_c = last;
      any_c  = 1'b0;
      cand_c = last;
      for (int k = N_REQ; k >= 1; k--) begin
         cand_c = IDX_W'(last + IDX_W'(k));
         if (req[cand_c]) begin
            pick_c = cand_c;
            any_c  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= IDX_W'(N_REQ - 1);
         hold_cnt <= '0;
         gnt_idx  <= '0;
         gnt_en   <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (any_c) begin
                  gnt_idx  <= pick_c;
                  gnt_en   <= 1'b1;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               // A dropped request wins over the hold limit, so no timeout is flagged then.
               if (!req[gnt_idx]) begin
                  gnt_en <= 1'b0;
                  last   <= gnt_idx;
                  state  <= IDLE;
               end else if (hold_cnt == HOLD_LAST) begin
                  gnt_en  <= 1'b0;
                  last    <= gnt_idx;
                  timeout <= 1'b1;
                  state   <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign busy = gnt_en;

endmodule
